// File: rtl/bit_serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice processes one operand bit per
// clock, LSB first, with the carry held in a flip-flop between bits.
module bit_serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             sum_bit;
  logic             carry_next;

  assign sum_bit    = op_a[0] ^ op_b[0] ^ carry;
  assign carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == LAST_BIT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted at load and the +1 enters as the initial carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      count     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
          end
        end
        SHIFT: begin
          result <= {sum_bit, result[WIDTH-1:1]};
          carry  <= carry_next;
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          count  <= count + 1'b1;
          // The MSB slice: its carry-in versus carry-out gives signed overflow.
          if (count == LAST_BIT) begin
            carry_out <= carry_next;
            overflow  <= carry ^ carry_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_add_sub.sv
// Self-checking bench for bit_serial_add_sub: an arithmetic reference model feeds a
// scoreboard queue that is drained whenever the DUT pulses done.
module tb_bit_serial_add_sub;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int   total;
  int   bad;
  int   done_count;
  exp_t exp_q[$];
  exp_t last_exp;

  bit_serial_add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference uses full-width addition and sign rules, independent of the serial datapath.
  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] full;
    logic [W-1:0] yy;
    yy     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, yy} + (W+1)'(s);
    e.res  = full[W-1:0];
    e.cout = full[W];
    if (s) e.ovf = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
    else   e.ovf = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
    return e;
  endfunction

  // Scoreboard drain: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        last_exp = exp_q.pop_front();
        checkOutput("result",    32'(result),    32'(last_exp.res));
        checkOutput("carry_out", 32'(carry_out), 32'(last_exp.cout));
        checkOutput("overflow",  32'(overflow),  32'(last_exp.ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && edges < 4 * W) begin
      if (busy === 1'b1) busy_cycles++;
      step();
      edges++;
    end
    if (done !== 1'b1) checkOutput("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic applyStimulus(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    int   edges;
    int   busy_cycles;
    exp_t e;
    e     = model(s, x, y);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    exp_q.push_back(e);
    step();
    start = 1'b0;
    a     = ~x;
    b     = ~y;
    sub   = ~s;
    waitDone(edges, busy_cycles);
    checkOutput("latency", 32'(edges), 32'(W));
    checkOutput("busy_cycles", 32'(busy_cycles), 32'(W));
    step();
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("result_hold", 32'(result), 32'(e.res));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},      32'(busy),      32'd0);
    checkOutput({tag, "_done"},      32'(done),      32'd0);
    checkOutput({tag, "_result"},    32'(result),    32'd0);
    checkOutput({tag, "_carry_out"}, 32'(carry_out), 32'd0);
    checkOutput({tag, "_overflow"},  32'(overflow),  32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int edges;
    int busy_cycles;
    total      = 0;
    bad        = 0;
    done_count = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    sub        = 1'b0;
    a          = '0;
    b          = '0;
    step();
    step();
    checkAllZero("reset");
    rst_n = 1'b1;
    step();

    applyStimulus(1'b0, 8'h35, 8'h4A);
    applyStimulus(1'b0, 8'hFF, 8'h01);
    applyStimulus(1'b0, 8'h7F, 8'h01);
    applyStimulus(1'b1, 8'h10, 8'h20);
    applyStimulus(1'b1, 8'h80, 8'h01);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    // Start held high: accepted at E0 and again at E10 with the operands present then.
    base  = done_count;
    start = 1'b1;
    sub   = 1'b0;
    a     = 8'h01;
    b     = 8'h02;
    exp_q.push_back(model(1'b0, 8'h01, 8'h02));
    step();
    checkOutput("hold_busy_e0", 32'(busy), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 3) begin
        a = 8'h10;
        b = 8'h20;
      end
      checkOutput($sformatf("hold_busy_e%0d", k), 32'(busy), 32'(k <= 7));
      checkOutput($sformatf("hold_done_e%0d", k), 32'(done), 32'(k == 8));
    end
    checkOutput("hold_done_count1", 32'(done_count - base), 32'd1);
    exp_q.push_back(model(1'b0, 8'h10, 8'h20));
    step();
    checkOutput("hold_busy_e10", 32'(busy), 32'd1);
    start = 1'b0;
    waitDone(edges, busy_cycles);
    step();
    checkOutput("hold_done_count2", 32'(done_count - base), 32'd2);

    // Leave nonzero carry_out/overflow so the reset clearing them is visible.
    applyStimulus(1'b1, 8'h80, 8'h01);

    // Reset mid-operation: aborted add must vanish without a done pulse.
    base  = done_count;
    start = 1'b1;
    sub   = 1'b0;
    a     = 8'h35;
    b     = 8'h4A;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    checkAllZero("abort");
    rst_n = 1'b1;
    for (int k = 0; k < 2 * W; k++) step();
    checkOutput("abort_no_done", 32'(done_count - base), 32'd0);
    applyStimulus(1'b1, 8'h80, 8'h01);

    // Reset while idle with start asserted: nothing may be accepted.
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'h55;
    b     = 8'h11;
    step();
    step();
    checkAllZero("idle_reset");
    start = 1'b0;
    rst_n = 1'b1;
    step();
    checkOutput("idle_reset_busy_after", 32'(busy), 32'd0);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
